// File: rtl/mpsoc_msi_ahb3_pkg.sv
`default_nettype none
// ============================================================================
// Module : mpsoc_msi_ahb3_pkg
// Brief  : Shared AHB3-Lite encodings and the slave-memory FSM state type.
//          HTRANS and HSIZE codes, HRESP values, and a helper that turns a
//          transfer size into a right-aligned byte-lane mask.
// Rev    : 1.0  initial release
// ============================================================================
package mpsoc_msi_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_t;

  // Lanes touched by a transfer of the given size, before shifting to the
  // byte offset. Oversized codes saturate; they are rejected as errors anyway.
  function automatic logic [7:0] size_lane_mask(input logic [2:0] size);
    logic [7:0] mask;
    case (size)
      HSIZE_BYTE:  mask = 8'h01;
      HSIZE_HWORD: mask = 8'h03;
      HSIZE_WORD:  mask = 8'h0F;
      default:     mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpsoc_msi_ahb3_ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module : mpsoc_msi_ahb3_ram_1r1w
// Brief  : Simple dual-port RAM, one synchronous read port and one write
//          port with per-byte enables. Read is read-before-write when both
//          ports hit the same word on the same edge. Contents are not reset.
// Ports  : clk_i    clock
//          raddr_i  read word index      rdata_o  registered read data
//          we_i     write enable         waddr_i  write word index
//          wbe_i    write byte enables   wdata_i  write data
// Rev    : 1.0  initial release
// ============================================================================
module mpsoc_msi_ahb3_ram_1r1w #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [XLEN-1:0]          rdata_o,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [XLEN/8-1:0]        wbe_i,
  input  logic [XLEN-1:0]          wdata_i
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mpsoc_msi_ahb3_slave_memory.sv
`default_nettype none
// ============================================================================
// Module : mpsoc_msi_ahb3_slave_memory
// Brief  : AHB3-Lite memory slave with configurable wait states, two-cycle
//          ERROR response for bad size/alignment/range, and byte-lane
//          forwarding so a read right behind a write sees the new data.
// Ports  : HCLK, HRESET (async, active-high)
//          HSEL, HADDR, HWDATA, HWRITE, HSIZE, HTRANS, HREADY  -- bus inputs
//          HBURST, HPROT, HMASTLOCK                          -- ignored
//          HRDATA, HREADYOUT, HRESP                          -- slave outputs
// Rev    : 1.0  initial release
// ============================================================================
module mpsoc_msi_ahb3_slave_memory
  import mpsoc_msi_ahb3_pkg::*;
#(
  parameter int PLEN  = 64,
  parameter int XLEN  = 64,
  parameter int DEPTH = 256,
  parameter int WAITS = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [PLEN:0] LIMIT     = (PLEN + 1)'(DEPTH * BYTES);
  localparam logic [2:0]    WAIT_LOAD = (WAITS > 0) ? 3'(WAITS - 1) : 3'd0;

  ahb_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-1:0]     word_q;
  logic [BYTES-1:0]  be_q;
  logic              write_q;
  logic [XLEN-1:0]   hrdata_q;
  logic              fwd_valid_q;
  logic [AW-1:0]     fwd_word_q;
  logic [BYTES-1:0]  fwd_be_q;
  logic [XLEN-1:0]   fwd_data_q;

  logic              accept, capture, misaligned, addr_err;
  logic [7:0]        lane_mask;
  logic [BYTES-1:0]  be_new;
  logic [AW-1:0]     raddr;
  logic              we;
  logic [XLEN-1:0]   ram_rdata, rdata_merged;
  logic              read_data_phase;
  logic              unused_ignored;

  assign unused_ignored = ^{HBURST, HPROT, HMASTLOCK};

  // Only NONSEQ/SEQ (HTRANS[1]=1) with the bus ready start a transfer.
  assign accept = HSEL && HREADY && HTRANS[1];

  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < OFFW; i++) begin
      if (HADDR[i] && (i < int'(HSIZE))) misaligned = 1'b1;
    end
  end

  assign addr_err  = (HSIZE > 3'(OFFW)) || misaligned || ({1'b0, HADDR} >= LIMIT);
  assign lane_mask = size_lane_mask(HSIZE);
  assign be_new    = lane_mask[BYTES-1:0] << HADDR[OFFW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        // Without HREADY the address phase is not sampled and we stay put.
        if (HREADY) begin
          if (accept) begin
            capture = 1'b1;
            if (addr_err) begin
              state_d = ST_ERR1;
            end else if (WAITS > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // The RAM reads the incoming address on the accept edge so data is ready
  // in DATA with zero waits; during WAIT it keeps re-reading the latched word.
  assign raddr = capture ? HADDR[OFFW +: AW] : word_q;
  assign we    = (state_q == ST_DATA) && HREADY && write_q;
  assign read_data_phase = (state_q == ST_DATA) && !write_q;

  mpsoc_msi_ahb3_ram_1r1w #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (HCLK),
    .raddr_i (raddr),
    .rdata_o (ram_rdata),
    .we_i    (we),
    .waddr_i (word_q),
    .wbe_i   (be_q),
    .wdata_i (HWDATA)
  );

  // The RAM read issued on the same edge as a write returns the old word;
  // patch in the lanes that write just committed.
  always_comb begin
    rdata_merged = ram_rdata;
    for (int b = 0; b < BYTES; b++) begin
      if (fwd_valid_q && (fwd_word_q == word_q) && fwd_be_q[b])
        rdata_merged[b*8 +: 8] = fwd_data_q[b*8 +: 8];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      word_q      <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      hrdata_q    <= '0;
      fwd_valid_q <= 1'b0;
      fwd_word_q  <= '0;
      fwd_be_q    <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fwd_valid_q <= we;
      if (capture) begin
        word_q  <= HADDR[OFFW +: AW];
        be_q    <= be_new;
        write_q <= HWRITE;
      end
      if (we) begin
        fwd_word_q <= word_q;
        fwd_be_q   <= be_q;
        fwd_data_q <= HWDATA;
      end
      if (read_data_phase) hrdata_q <= rdata_merged;
    end
  end

  assign HRDATA    = read_data_phase ? rdata_merged : hrdata_q;
  assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_mpsoc_msi_ahb3_slave_memory.sv
`default_nettype none
// ============================================================================
// Module : tb_mpsoc_msi_ahb3_slave_memory
// Brief  : Directed self-checking bench. Instance u_dut0 has WAITS=0,
//          u_dut2 has WAITS=2; sel2 chooses which one the bus talks to.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mpsoc_msi_ahb3_slave_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        bsel, sel2;
  logic [63:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  wire         rdy0, rdy2, resp0, resp2;
  wire [63:0]  rd0, rd2;
  wire         hsel0   = bsel & ~sel2;
  wire         hsel2   = bsel & sel2;
  wire         hready0 = sel2 ? 1'b1 : rdy0;
  wire         hready2 = sel2 ? rdy2 : 1'b1;
  wire         cur_ro  = sel2 ? rdy2 : rdy0;
  wire         cur_rsp = sel2 ? resp2 : resp0;
  wire [63:0]  cur_rd  = sel2 ? rd2 : rd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mpsoc_msi_ahb3_slave_memory #(.PLEN(64), .XLEN(64), .DEPTH(256), .WAITS(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd3),
    .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  mpsoc_msi_ahb3_slave_memory #(.PLEN(64), .XLEN(64), .DEPTH(256), .WAITS(2)) u_dut2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel2), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd2), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd3),
    .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready2), .HREADYOUT(rdy2), .HRESP(resp2)
  );

  // One non-pipelined transfer. Entered and left 1 time unit after a rising edge.
  task automatic xfer(input logic t2, input logic w, input logic [63:0] a, input logic [2:0] s,
                      input logic [63:0] wd, output logic [63:0] rd, output logic rsp,
                      output logic rsp_first, output int lows);
    logic done;
    done = 1'b0; lows = 0; rd = '0; rsp = 1'b0; rsp_first = 1'b0;
    sel2 = t2; bsel = 1'b1; htrans = 2'd2; haddr = a; hwrite = w; hsize = s;
    @(posedge clk); #1;
    bsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = wd;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) rsp_first = cur_rsp;
      if (cur_ro) begin
        rd = cur_rd; rsp = cur_rsp; done = 1'b1;
        break;
      end
      lows++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL xfer_timeout: addr %h got no HREADYOUT after %0d cycles, required completion", a, lows);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bsel = 1'b0; sel2 = 1'b0; htrans = 2'd0; haddr = '0;
    hwdata = '0; hwrite = 1'b0; hsize = 3'd0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL reset_ready0: got %b required 1", rdy0); end
    n_cmp++; if (resp0 !== 1'b0) begin n_err++; $display("FAIL reset_resp0: got %b required 0", resp0); end
    n_cmp++; if (rd0 !== 64'd0) begin n_err++; $display("FAIL reset_rdata0: got %h required 0", rd0); end
    n_cmp++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL reset_ready2: got %b required 1", rdy2); end
    n_cmp++; if (resp2 !== 1'b0) begin n_err++; $display("FAIL reset_resp2: got %b required 0", resp2); end
    n_cmp++; if (rd2 !== 64'd0) begin n_err++; $display("FAIL reset_rdata2: got %h required 0", rd2); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic all_high;
    all_high = 1'b1;
    sel2 = 1'b0; bsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 64'h10; hsize = 3'd3;
    @(negedge clk); all_high &= rdy0;
    @(posedge clk); #1;
    hwrite = 1'b0; haddr = 64'h10; hwdata = 64'h1122334455667788;
    @(negedge clk); all_high &= rdy0;
    @(posedge clk); #1;
    bsel = 1'b0; htrans = 2'd0;
    @(negedge clk); all_high &= rdy0;
    n_cmp++; if (rd0 !== 64'h1122334455667788) begin n_err++; $display("FAIL b2b_fwd_data: got %h required 1122334455667788", rd0); end
    n_cmp++; if (resp0 !== 1'b0) begin n_err++; $display("FAIL b2b_resp: got %b required 0", resp0); end
    @(posedge clk); #1;
    n_cmp++; if (all_high !== 1'b1) begin n_err++; $display("FAIL b2b_no_wait: got %b required 1", all_high); end
  endtask

  task automatic test_byte_lanes;
    logic [63:0] rd; logic rsp, rf; int lows;
    xfer(1'b0, 1'b1, 64'h13, 3'd0, 64'h00000000AB000000, rd, rsp, rf, lows);
    n_cmp++; if (rsp !== 1'b0) begin n_err++; $display("FAIL byte_wr_resp: got %b required 0", rsp); end
    xfer(1'b0, 1'b0, 64'h10, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rd !== 64'h11223344AB667788) begin n_err++; $display("FAIL byte_lane3: got %h required 11223344ab667788", rd); end
    @(negedge clk);
    n_cmp++; if (rd0 !== 64'h11223344AB667788) begin n_err++; $display("FAIL rdata_hold: got %h required 11223344ab667788", rd0); end
    @(posedge clk); #1;
    xfer(1'b0, 1'b1, 64'h16, 3'd1, 64'hBEEF000000000000, rd, rsp, rf, lows);
    xfer(1'b0, 1'b0, 64'h10, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rd !== 64'hBEEF3344AB667788) begin n_err++; $display("FAIL hword_lanes67: got %h required beef3344ab667788", rd); end
  endtask

  task automatic test_misaligned;
    logic [63:0] rd; logic rsp, rf; int lows;
    xfer(1'b0, 1'b1, 64'h11, 3'd1, 64'hFFFFFFFFFFFFFFFF, rd, rsp, rf, lows);
    n_cmp++; if (lows !== 1) begin n_err++; $display("FAIL misal_low_cycles: got %0d required 1", lows); end
    n_cmp++; if (rf !== 1'b1) begin n_err++; $display("FAIL misal_err1_resp: got %b required 1", rf); end
    n_cmp++; if (rsp !== 1'b1) begin n_err++; $display("FAIL misal_err2_resp: got %b required 1", rsp); end
    xfer(1'b0, 1'b0, 64'h12, 3'd2, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rsp !== 1'b1) begin n_err++; $display("FAIL misal_word_resp: got %b required 1", rsp); end
    xfer(1'b0, 1'b0, 64'h10, 3'd4, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rsp !== 1'b1) begin n_err++; $display("FAIL oversize_resp: got %b required 1", rsp); end
    xfer(1'b0, 1'b0, 64'h10, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rd !== 64'hBEEF3344AB667788) begin n_err++; $display("FAIL misal_no_write: got %h required beef3344ab667788", rd); end
  endtask

  task automatic test_out_of_range;
    logic [63:0] rd; logic rsp, rf; int lows;
    xfer(1'b0, 1'b1, 64'h0, 3'd3, 64'h0123456789ABCDEF, rd, rsp, rf, lows);
    xfer(1'b0, 1'b1, 64'h800, 3'd3, 64'hFFFFFFFFFFFFFFFF, rd, rsp, rf, lows);
    n_cmp++; if (lows !== 1 || rf !== 1'b1 || rsp !== 1'b1) begin
      n_err++; $display("FAIL oor_write_err: got lows=%0d resp1=%b resp2=%b required 1/1/1", lows, rf, rsp);
    end
    xfer(1'b0, 1'b0, 64'h800, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rsp !== 1'b1) begin n_err++; $display("FAIL oor_read_resp: got %b required 1", rsp); end
    xfer(1'b0, 1'b0, 64'h0, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rd !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL oor_no_wrap: got %h required 0123456789abcdef", rd); end
    xfer(1'b0, 1'b1, 64'h7F8, 3'd3, 64'hA5A55A5A0F0FF0F0, rd, rsp, rf, lows);
    xfer(1'b0, 1'b0, 64'h7F8, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rd !== 64'hA5A55A5A0F0FF0F0 || rsp !== 1'b0) begin
      n_err++; $display("FAIL last_word: got %h resp=%b required a5a55a5a0f0ff0f0 resp=0", rd, rsp);
    end
  endtask

  task automatic test_idle_busy;
    sel2 = 1'b0; bsel = 1'b1; htrans = 2'd1; haddr = 64'h800; hwrite = 1'b0; hsize = 3'd3;
    @(posedge clk); #1;
    htrans = 2'd0;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin
      n_err++; $display("FAIL busy_okay: got ready=%b resp=%b required 1/0", rdy0, resp0);
    end
    @(posedge clk); #1;
    bsel = 1'b0;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin
      n_err++; $display("FAIL idle_okay: got ready=%b resp=%b required 1/0", rdy0, resp0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states;
    logic [63:0] rd; logic rsp, rf; int lows;
    xfer(1'b1, 1'b1, 64'h0, 3'd3, 64'h0F1E2D3C4B5A6978, rd, rsp, rf, lows);
    n_cmp++; if (lows !== 2) begin n_err++; $display("FAIL wait_write_lows: got %0d required 2", lows); end
    xfer(1'b1, 1'b0, 64'h0, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (lows !== 2) begin n_err++; $display("FAIL wait_read_lows: got %0d required 2", lows); end
    n_cmp++; if (rf !== 1'b0 || rsp !== 1'b0) begin
      n_err++; $display("FAIL wait_read_resp: got %b/%b required 0/0", rf, rsp);
    end
    n_cmp++; if (rd !== 64'h0F1E2D3C4B5A6978) begin n_err++; $display("FAIL wait_read_data: got %h required 0f1e2d3c4b5a6978", rd); end
  endtask

  task automatic test_mid_reset;
    logic [63:0] rd; logic rsp, rf; int lows;
    sel2 = 1'b1; bsel = 1'b1; htrans = 2'd2; haddr = 64'h0; hwrite = 1'b1; hsize = 3'd3;
    @(posedge clk); #1;
    bsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    n_cmp++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL midrst_in_wait: got %b required 0", rdy2); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (rdy2 !== 1'b1 || resp2 !== 1'b0 || rd2 !== 64'd0) begin
      n_err++; $display("FAIL midrst_outputs: got ready=%b resp=%b rdata=%h required 1/0/0", rdy2, resp2, rd2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 64'h0, 3'd3, 64'd0, rd, rsp, rf, lows);
    n_cmp++; if (rd !== 64'h0F1E2D3C4B5A6978) begin n_err++; $display("FAIL midrst_no_commit: got %h required 0f1e2d3c4b5a6978", rd); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_misaligned();
    test_out_of_range();
    test_idle_busy();
    test_wait_states();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
